// File: rtl/arith_op_scheduler.sv
// -----------------------------------------------------------------------------
// arith_op_scheduler
//
// Shared arithmetic controller. Two requesters (ch0, ch1) submit unsigned add
// or multiply jobs. A round-robin arbiter picks one job at a time. The job
// runs on a single 2*WIDTH-bit adder:
//   - an add finishes in one cycle;
//   - a multiply takes exactly WIDTH shift-add steps on the same adder.
// The result comes back on one tagged valid/ready response channel.
//
// Ports
//   i_clk, i_reset                  clock, asynchronous active-high reset
//   i_reqN_valid / o_reqN_ready     job handshake for channel N (0 or 1)
//   i_reqN_op                       0 = add, 1 = mul
//   i_reqN_a, i_reqN_b              WIDTH-bit unsigned operands
//   o_rsp_valid / i_rsp_ready       response handshake
//   o_rsp_id                        channel that issued the job
//   o_rsp_op                        opcode of the job
//   o_rsp_result                    2*WIDTH-bit result
//   o_busy                          high whenever the controller is not idle
// -----------------------------------------------------------------------------
module arith_op_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_req0_valid,
    output logic                 o_req0_ready,
    input  logic                 i_req0_op,
    input  logic [WIDTH-1:0]     i_req0_a,
    input  logic [WIDTH-1:0]     i_req0_b,
    input  logic                 i_req1_valid,
    output logic                 o_req1_ready,
    input  logic                 i_req1_op,
    input  logic [WIDTH-1:0]     i_req1_a,
    input  logic [WIDTH-1:0]     i_req1_b,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic                 o_rsp_id,
    output logic                 o_rsp_op,
    output logic [2*WIDTH-1:0]   o_rsp_result,
    output logic                 o_busy
);

    localparam int RES_W = 2 * WIDTH;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_MUL  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_next_s;

    logic               last_grant_r;
    logic               grant_s;
    logic               idle_s;
    logic               accept_s;
    logic               op_sel_s;
    logic [WIDTH-1:0]   a_sel_s;
    logic [WIDTH-1:0]   b_sel_s;

    logic               id_r;
    logic               op_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [RES_W-1:0]   acc_r;
    logic [RES_W-1:0]   result_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               rsp_valid_r;
    logic               busy_r;

    logic [RES_W-1:0]   add_x_s;
    logic [RES_W-1:0]   add_y_s;
    logic [RES_W-1:0]   sum_s;
    logic               mul_last_s;

    // Round-robin choice: a lone requester wins, a tie goes to the channel not served last.
    always_comb begin
        grant_s = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            grant_s = ~last_grant_r;
        end else if (i_req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Readies are gated by reset so they drop at once with the asynchronous reset.
    assign idle_s       = (state_r == ST_IDLE) && !i_reset;
    assign o_req0_ready = idle_s && i_req0_valid && (grant_s == 1'b0);
    assign o_req1_ready = idle_s && i_req1_valid && (grant_s == 1'b1);
    assign accept_s     = o_req0_ready || o_req1_ready;

    assign op_sel_s = grant_s ? i_req1_op : i_req0_op;
    assign a_sel_s  = grant_s ? i_req1_a  : i_req0_a;
    assign b_sel_s  = grant_s ? i_req1_b  : i_req0_b;

    assign mul_last_s = (cnt_r == CNT_W'(WIDTH - 1));

    // Operand mux for the single shared adder: plain add, or accumulate one partial product.
    always_comb begin
        add_x_s = {RES_W{1'b0}};
        add_y_s = {RES_W{1'b0}};
        case (state_r)
            ST_ADD: begin
                add_x_s = {{WIDTH{1'b0}}, a_r};
                add_y_s = {{WIDTH{1'b0}}, b_r};
            end
            ST_MUL: begin
                add_x_s = acc_r;
                if (b_r[cnt_r]) begin
                    add_y_s = {{WIDTH{1'b0}}, a_r} << cnt_r;
                end else begin
                    add_y_s = {RES_W{1'b0}};
                end
            end
            default: begin
                add_x_s = {RES_W{1'b0}};
                add_y_s = {RES_W{1'b0}};
            end
        endcase
    end

    assign sum_s = add_x_s + add_y_s;

    // Next-state logic of the job sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = op_sel_s ? ST_MUL : ST_ADD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ADD: begin
                state_next_s = ST_RESP;
            end
            ST_MUL: begin
                if (mul_last_s) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_MUL;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Job capture, multiply iteration and registered response outputs.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            last_grant_r <= 1'b1;
            id_r         <= 1'b0;
            op_r         <= 1'b0;
            a_r          <= {WIDTH{1'b0}};
            b_r          <= {WIDTH{1'b0}};
            acc_r        <= {RES_W{1'b0}};
            result_r     <= {RES_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            rsp_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            // Valid and busy are registered versions of the state being entered.
            rsp_valid_r <= (state_next_s == ST_RESP);
            busy_r      <= (state_next_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        last_grant_r <= grant_s;
                        id_r         <= grant_s;
                        op_r         <= op_sel_s;
                        a_r          <= a_sel_s;
                        b_r          <= b_sel_s;
                        acc_r        <= {RES_W{1'b0}};
                        cnt_r        <= {CNT_W{1'b0}};
                    end
                end
                ST_ADD: begin
                    result_r <= sum_s;
                end
                ST_MUL: begin
                    acc_r <= sum_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    // The final step's sum includes the top partial product.
                    if (mul_last_s) begin
                        result_r <= sum_s;
                    end
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    assign o_rsp_valid  = rsp_valid_r;
    assign o_rsp_id     = id_r;
    assign o_rsp_op     = op_r;
    assign o_rsp_result = result_r;
    assign o_busy       = busy_r;

endmodule

// File: tb/tb_arith_op_scheduler.sv
// -----------------------------------------------------------------------------
// tb_arith_op_scheduler
//
// Directed, self-checking bench for arith_op_scheduler (WIDTH = 8).
// Inputs are driven 1 time unit after the rising edge, and outputs are sampled
// there as well.
// -----------------------------------------------------------------------------
module tb_arith_op_scheduler;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, req0_op;
    logic [7:0]  req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_op;
    logic [7:0]  req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_op, busy;
    logic [15:0] rsp_result;

    int checks   = 0;
    int failures = 0;
    bit both_ready_seen = 1'b0;

    arith_op_scheduler #(.WIDTH(8)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_req0_valid (req0_valid),
        .o_req0_ready (req0_ready),
        .i_req0_op    (req0_op),
        .i_req0_a     (req0_a),
        .i_req0_b     (req0_b),
        .i_req1_valid (req1_valid),
        .o_req1_ready (req1_ready),
        .i_req1_op    (req1_op),
        .i_req1_a     (req1_a),
        .i_req1_b     (req1_b),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_id     (rsp_id),
        .o_rsp_op     (rsp_op),
        .o_rsp_result (rsp_result),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watch for two readies in the same cycle.
    always @(negedge clk) begin
        if (req0_ready && req1_ready) both_ready_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single job on one channel, the other channel idle; response taken immediately.
    task automatic run_job(input bit ch, input bit op, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] exp_res, input int exp_lat, input string tag);
        int lat;
        bit busy_low;
        if (ch == 1'b0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
        #1;
        check({tag, ".ready_own"},   ch ? req1_ready : req0_ready, 32'd1);
        check({tag, ".ready_other"}, ch ? req0_ready : req1_ready, 32'd0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check({tag, ".valid_early"}, rsp_valid, 32'd0);
        lat = 0;
        busy_low = 1'b0;
        while (!rsp_valid && lat < 20) begin
            if (!busy) busy_low = 1'b1;
            step();
            lat++;
        end
        check({tag, ".latency"}, lat, exp_lat);
        check({tag, ".busy"},    busy_low, 32'd0);
        check({tag, ".id"},      rsp_id, ch);
        check({tag, ".op"},      rsp_op, op);
        check({tag, ".result"},  rsp_result, exp_res);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({tag, ".valid_after"}, rsp_valid, 32'd0);
        check({tag, ".idle_busy"},   busy, 32'd0);
        check({tag, ".result_hold"}, rsp_result, exp_res);
    endtask

    initial begin : main
        int grants[$];
        int ids[$];
        logic [15:0] results[$];
        bit valid_seen;

        rst = 1'b1;
        req0_valid = 1'b0; req0_op = 1'b0; req0_a = 8'h00; req0_b = 8'h00;
        req1_valid = 1'b0; req1_op = 1'b0; req1_a = 8'h00; req1_b = 8'h00;
        rsp_ready = 1'b0;
        step();
        step();

        // Reset state
        check("rst.valid",  rsp_valid,  32'd0);
        check("rst.id",     rsp_id,     32'd0);
        check("rst.op",     rsp_op,     32'd0);
        check("rst.result", rsp_result, 32'd0);
        check("rst.busy",   busy,       32'd0);
        check("rst.ready0", req0_ready, 32'd0);
        check("rst.ready1", req1_ready, 32'd0);
        rst = 1'b0;
        step();

        // Adds
        run_job(1'b0, 1'b0, 8'h30, 8'h14, 16'h0044, 1, "add0");
        run_job(1'b1, 1'b0, 8'hFC, 8'h04, 16'h0100, 1, "add1_carry");
        run_job(1'b1, 1'b0, 8'hFF, 8'hFF, 16'h01FE, 1, "add1_max");

        // Response back-pressure: ch0 wins (last grant was ch1), ch1 waits.
        req0_valid = 1'b1; req0_op = 1'b0; req0_a = 8'h05; req0_b = 8'h06;
        req1_valid = 1'b1; req1_op = 1'b0; req1_a = 8'h10; req1_b = 8'h20;
        #1;
        check("hold.ready0", req0_ready, 32'd1);
        check("hold.ready1", req1_ready, 32'd0);
        step();
        req0_valid = 1'b0;
        check("hold.ready1_busy", req1_ready, 32'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            check("hold.valid",  rsp_valid,  32'd1);
            check("hold.result", rsp_result, 32'h000B);
            check("hold.id",     rsp_id,     32'd0);
            check("hold.ready1", req1_ready, 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        check("hold.ready1_hs", req1_ready, 32'd0);
        step();
        rsp_ready = 1'b0;
        check("hold.valid_after", rsp_valid,  32'd0);
        check("hold.ready1_next", req1_ready, 32'd1);
        step();
        req1_valid = 1'b0;
        step();
        check("hold2.valid",  rsp_valid,  32'd1);
        check("hold2.id",     rsp_id,     32'd1);
        check("hold2.result", rsp_result, 32'h0030);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // Both channels valid continuously: grants must alternate 0,1,0,1.
        req0_valid = 1'b1; req0_op = 1'b1; req0_a = 8'h12; req0_b = 8'h34;
        req1_valid = 1'b1; req1_op = 1'b0; req1_a = 8'h01; req1_b = 8'h02;
        rsp_ready = 1'b1;
        #1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            if (rsp_valid) begin
                ids.push_back(int'(rsp_id));
                results.push_back(rsp_result);
            end
            if (results.size() >= 4) break;
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        rsp_ready = 1'b0;
        check("rr.resp_count", results.size(), 32'd4);
        check("rr.grant_count", grants.size(), 32'd4);
        if (grants.size() >= 4 && results.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check("rr.grant",  grants[i], i % 2);
                check("rr.id",     ids[i],    i % 2);
                check("rr.result", results[i], (i % 2 == 0) ? 32'h03A8 : 32'h0003);
            end
        end
        check("rr.one_ready", both_ready_seen, 32'd0);

        // Multiplies: fixed 8-cycle latency
        run_job(1'b0, 1'b1, 8'h00, 8'hAB, 16'h0000, 8, "mul_zero");
        run_job(1'b0, 1'b1, 8'hFF, 8'hFF, 16'hFE01, 8, "mul_max");
        run_job(1'b0, 1'b1, 8'hFC, 8'h04, 16'h03F0, 8, "mul_fc4");

        // Reset during cycle 4 of a multiply
        req0_valid = 1'b1; req0_op = 1'b1; req0_a = 8'h12; req0_b = 8'h34;
        #1;
        check("abort.ready0", req0_ready, 32'd1);
        step();
        req0_valid = 1'b0;
        step();
        step();
        step();
        check("abort.busy_before", busy, 32'd1);
        rst = 1'b1;
        #1;
        check("abort.valid",  rsp_valid,  32'd0);
        check("abort.busy",   busy,       32'd0);
        check("abort.id",     rsp_id,     32'd0);
        check("abort.op",     rsp_op,     32'd0);
        check("abort.result", rsp_result, 32'd0);
        step();
        rst = 1'b0;
        valid_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (rsp_valid) valid_seen = 1'b1;
            step();
        end
        check("abort.no_rsp", valid_seen, 32'd0);
        req0_valid = 1'b1; req0_op = 1'b0; req0_a = 8'h22; req0_b = 8'h11;
        req1_valid = 1'b1; req1_op = 1'b0; req1_a = 8'h40; req1_b = 8'h01;
        #1;
        check("post.ready0", req0_ready, 32'd1);
        check("post.ready1", req1_ready, 32'd0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        check("post.valid",  rsp_valid,  32'd1);
        check("post.id",     rsp_id,     32'd0);
        check("post.result", rsp_result, 32'h0033);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("final.one_ready", both_ready_seen, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
